// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
//   Shared definitions for the configuration sequencer: module-flag codes
//   carried in config_addr[31:16], address field bounds, the buffered word
//   record and the sequencer state encoding.
//   Optional feature macro: CFG_ADDR_CHECK_EN (flag legality, see flag_legal).
// ---------------------------------------------------------------------------
package cfg_pkg;

    localparam logic [15:0] FLAG_IDLE = 16'd0;
    localparam logic [15:0] FLAG_CLB  = 16'd4;
    localparam logic [15:0] FLAG_CB1  = 16'd5;
    localparam logic [15:0] FLAG_CB0  = 16'd6;
    localparam logic [15:0] FLAG_SB   = 16'd7;

    localparam int unsigned TILE_ID_LSB = 0;
    localparam int unsigned TILE_ID_MSB = 15;
    localparam int unsigned FLAG_LSB    = 16;
    localparam int unsigned FLAG_MSB    = 31;

    // 65-bit buffered word: {last, addr, data}
    typedef struct packed {
        logic        last;
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A flag addresses a real tile module only in the CLB..SB range.
    function automatic logic flag_legal(input logic [15:0] flag);
        return (flag >= FLAG_CLB) && (flag <= FLAG_SB);
    endfunction

endpackage

// File: rtl/cfg_fifo.sv
// ---------------------------------------------------------------------------
// cfg_fifo
//   Synchronous FIFO buffering {last, addr, data} configuration words.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset (flushes pointers)
//     push         write wr_word (ignored when full, even if popping)
//     wr_word      word to write
//     pop          drop the head word (ignored when empty)
//     rd_word      current head word (valid when !empty)
//     full, empty  occupancy flags
// ---------------------------------------------------------------------------
module cfg_fifo
    import cfg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  cfg_word_t wr_word,
    input  logic      pop,
    output cfg_word_t rd_word,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    cfg_word_t   mem_q [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end

endmodule

// File: rtl/config_sequencer.sv
// ---------------------------------------------------------------------------
// config_sequencer
//   Buffers host configuration words and drives the shared tile config bus.
//   Each word is held HOLD_CYCLES cycles followed by one idle (addr 0) gap so
//   every tile address matcher deasserts between writes. A word tagged
//   in_last produces a one-cycle done pulse after its gap; words_written
//   counts words driven since the last done (saturating).
//   Optional feature: `define CFG_ADDR_CHECK_EN drops words whose flag is
//   outside CLB..SB (never driven, not counted) and sets sticky err.
//   Ports:
//     clk, reset              clock, asynchronous active-high reset
//     in_valid/in_ready       host handshake (in_ready = !full, 0 in reset)
//     in_addr/in_data/in_last host word
//     config_addr/config_data registered tile bus
//     busy                    FIFO non-empty or sequencer not idle
//     done                    end-of-bitstream pulse
//     words_written           words driven since last done
//     err                     sticky illegal-flag error (0 without check)
// ---------------------------------------------------------------------------
module config_sequencer
    import cfg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_written,
    output logic        err
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  hold_q, hold_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic [15:0] words_written_q, words_written_d;
`ifdef CFG_ADDR_CHECK_EN
    logic        err_q, err_d;
`endif

    cfg_word_t   wr_word;
    cfg_word_t   head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        try_load;
    logic        head_legal;

    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign wr_word  = '{last: in_last, addr: in_addr, data: in_data};

    cfg_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wr_word(wr_word),
        .pop    (pop),
        .rd_word(head),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        data_d          = data_q;
        hold_d          = hold_q;
        last_d          = last_q;
        words_written_d = words_written_q;
        pop             = 1'b0;
        try_load        = 1'b0;
`ifdef CFG_ADDR_CHECK_EN
        err_d           = err_q;
        head_legal      = flag_legal(head.addr[FLAG_MSB:FLAG_LSB]);
`else
        head_legal      = 1'b1;
`endif

        case (state_q)
            IDLE: try_load = 1'b1;
            DRIVE: begin
                if (hold_q == '0) begin
                    pop    = 1'b1;
                    addr_d = '0;
                    data_d = '0;
                    if (words_written_q != '1) words_written_d = words_written_q + 16'd1;
                    state_d = GAP;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            GAP: begin
                if (last_q) state_d = DONE;
                else        try_load = 1'b1;
            end
            DONE: begin
                words_written_d = '0;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The gap cycle shares IDLE's load path, so back-to-back words see
        // exactly one idle cycle between them.
        if (try_load) begin
            state_d = IDLE;
            if (!empty) begin
                if (head_legal) begin
                    addr_d  = head.addr;
                    data_d  = head.data;
                    last_d  = head.last;
                    hold_d  = HOLD_LAST;
                    state_d = DRIVE;
                end else begin
                    // Illegal word is discarded without touching the bus;
                    // its end-of-bitstream marker still closes the stream.
                    pop = 1'b1;
`ifdef CFG_ADDR_CHECK_EN
                    err_d = 1'b1;
`endif
                    if (head.last) state_d = DONE;
                end
            end
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            hold_q          <= '0;
            last_q          <= 1'b0;
            done_q          <= 1'b0;
            words_written_q <= '0;
`ifdef CFG_ADDR_CHECK_EN
            err_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            hold_q          <= hold_d;
            last_q          <= last_d;
            done_q          <= done_d;
            words_written_q <= words_written_d;
`ifdef CFG_ADDR_CHECK_EN
            err_q           <= err_d;
`endif
        end
    end

    assign config_addr   = addr_q;
    assign config_data   = data_q;
    assign done          = done_q;
    assign words_written = words_written_q;
    assign busy          = !empty || (state_q != IDLE);
`ifdef CFG_ADDR_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_config_sequencer
//   Directed and random stimulus against a schedule-based reference: each
//   accepted word is given a bus start time from the hold/gap/done timing
//   rules, and every output is predicted from those times each cycle.
// ---------------------------------------------------------------------------
module tb_config_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic [15:0] words_written;
    logic        err;

    config_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_last      (in_last),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .busy         (busy),
        .done         (done),
        .words_written(words_written),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        int          k;
    } ent_t;

    ent_t pend[$];
    ent_t act;
    bit   act_on;
    int   act_s;
    int   c;
    int   next_free;
    int   done_at;
    int   clr_at;
    int   busy_until;
    int   ww_m;
    bit   err_m;
    bit   ready_pred;
    int   n_started;
    int   checks;
    int   errors;

    logic [15:0] flag_tab [7] = '{16'h0, 16'h4, 16'h5, 16'h6, 16'h7, 16'h9, 16'h3};

    function automatic bit legal(input logic [31:0] a);
`ifdef CFG_ADDR_CHECK_EN
        return (a[31:16] >= 16'd4) && (a[31:16] <= 16'd7);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, c, got, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        act_on     = 1'b0;
        act_s      = 0;
        next_free  = 0;
        done_at    = -100;
        clr_at     = -100;
        busy_until = -100;
        ww_m       = 0;
        err_m      = 1'b0;
    endtask

    // One clock: drive inputs, advance, update the reference, compare.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic l);
        ent_t        e;
        int          occ;
        logic [31:0] ea;
        logic [31:0] ed;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        c++;
        if (v && ready_pred) begin
            e.addr = a; e.data = d; e.last = l; e.k = c;
            pend.push_back(e);
        end
        if (act_on && c == act_s + HOLD && ww_m < 65535) ww_m++;
        if (c == clr_at) ww_m = 0;
        if (c >= next_free && pend.size() > 0 && pend[0].k + 1 <= c) begin
            e = pend.pop_front();
            n_started++;
            if (legal(e.addr)) begin
                act        = e;
                act_on     = 1'b1;
                act_s      = c;
                next_free  = c + HOLD + 1 + (e.last ? 2 : 0);
                busy_until = c + HOLD + (e.last ? 1 : 0);
                if (e.last) begin
                    done_at = c + HOLD + 1;
                    clr_at  = c + HOLD + 2;
                end
            end else begin
                err_m = 1'b1;
                if (e.last) begin
                    done_at    = c;
                    clr_at     = c + 1;
                    next_free  = c + 2;
                    busy_until = c;
                end else begin
                    next_free = c + 1;
                end
            end
        end
        occ = pend.size() + ((act_on && c < act_s + HOLD) ? 1 : 0);
        ea  = (act_on && c >= act_s && c < act_s + HOLD) ? act.addr : 32'h0;
        ed  = (act_on && c >= act_s && c < act_s + HOLD) ? act.data : 32'h0;
        #1;
        check_eq("config_addr", config_addr, ea);
        check_eq("config_data", config_data, ed);
        check_eq("in_ready", 32'(in_ready), 32'(occ < DEPTH));
        check_eq("busy", 32'(busy), 32'(occ > 0 || c <= busy_until));
        check_eq("done", 32'(done), 32'(c == done_at));
        check_eq("words_written", 32'(words_written), 32'(ww_m));
        check_eq("err", 32'(err), 32'(err_m));
        ready_pred = (occ < DEPTH);
    endtask

    task automatic check_reset_outputs(input logic exp_ready);
        check_eq("rst_addr", config_addr, 32'h0);
        check_eq("rst_data", config_data, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_ww", 32'(words_written), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_ready", 32'(in_ready), 32'(exp_ready));
    endtask

    initial begin
        int mark;
        bit found;
        checks     = 0;
        errors     = 0;
        c          = 0;
        n_started  = 0;
        ready_pred = 1'b0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_data    = '0;
        in_last    = 1'b0;
        model_reset();

        // Reset held for three cycles, then released away from the edge.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs(1'b1);
        ready_pred = 1'b1;

        // Single last word.
        step(1'b1, 32'h0004_0003, 32'h2, 1'b1);
        repeat (10) step(1'b0, '0, '0, 1'b0);

        // Six back-to-back words overflow the buffer; in_ready must back off.
        for (int i = 0; i < 6; i++)
            step(1'b1, {16'(4 + i % 4), 16'(i)}, 32'hA000_0000 + 32'(i), i == 5);
        repeat (40) step(1'b0, '0, '0, 1'b0);

        // Two words, hold and gap period.
        step(1'b1, 32'h0005_0010, 32'h1111_1111, 1'b0);
        step(1'b1, 32'h0006_0011, 32'h2222_2222, 1'b1);
        repeat (15) step(1'b0, '0, '0, 1'b0);

        // Reset while the second of four words is on the bus.
        mark = n_started;
        for (int i = 0; i < 4; i++)
            step(1'b1, {16'h7, 16'(i + 32)}, 32'hB000_0000 + 32'(i), i == 3);
        found = (n_started == mark + 2 && act_on && c == act_s);
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, '0, '0, 1'b0);
            found = (n_started == mark + 2 && act_on && c == act_s);
        end
        check_eq("wait_word2", 32'(found), 32'h1);
        check_eq("word2_on_bus", config_addr, 32'h0007_0021);
        reset = 1'b1;
        #1;
        check_reset_outputs(1'b0);
        repeat (2) begin
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        ready_pred = 1'b1;
        repeat (12) step(1'b0, '0, '0, 1'b0);

`ifdef CFG_ADDR_CHECK_EN
        // Illegal flag 9 is dropped; the following legal last word completes.
        step(1'b1, 32'h0009_0001, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 32'h0007_0002, 32'h0000_0055, 1'b1);
        repeat (8) step(1'b0, '0, '0, 1'b0);
        check_eq("chk_err", 32'(err), 32'h1);
        repeat (4) step(1'b0, '0, '0, 1'b0);
`endif

        // Random traffic with mixed flags, bursts and end markers.
        repeat (500) begin
            logic [15:0] f;
            f = flag_tab[$urandom_range(0, 6)];
            step($urandom_range(0, 3) != 0, {f, 16'($urandom)}, 32'($urandom),
                 $urandom_range(0, 6) == 0);
        end
        repeat (60) step(1'b0, '0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
